// File: rtl/hls_deadlock_persist_monitor.sv
// Deadlock monitor for one HLS dataflow instance: asserts block once the aggregated
// stream/sub-instance block condition has persisted THRESH consecutive cycles.
module hls_deadlock_persist_monitor #(
    parameter int unsigned N_AXIS = 4,
    parameter int unsigned N_SUB  = 2,
    parameter int unsigned THRESH = 16,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned STICKY = 0
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [N_AXIS-1:0]                      axis_block_sigs,
    input  logic [((N_SUB > 0) ? N_SUB : 1)-1:0]   inst_idle_sigs,
    input  logic [((N_SUB > 0) ? N_SUB : 1)-1:0]   inst_block_sigs,
    input  logic                                   clear,
    output logic                                   block,
    output logic [N_AXIS+N_SUB-1:0]                block_src,
    output logic [CNT_W-1:0]                       block_cycles
);

    localparam int unsigned SRC_W = N_AXIS + N_SUB;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(THRESH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_BLOCKED = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SRC_W-1:0] src_q, src_d;
    logic             block_q, block_d;

    logic             sub_blk;
    logic             cond;
    logic [SRC_W-1:0] snap;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_sat;

    // Sub-instance term: every sub is idle or blocked, and at least one is blocked.
    generate
        if (N_SUB > 0) begin : g_sub
            assign sub_blk = (&(inst_idle_sigs | inst_block_sigs)) & (|inst_block_sigs);
            assign snap    = {inst_block_sigs, axis_block_sigs};
        end else begin : g_nosub
            logic unused_sub;
            assign unused_sub = ^{inst_idle_sigs, inst_block_sigs};
            assign sub_blk    = 1'b0;
            assign snap       = axis_block_sigs;
        end
    endgenerate

    assign cond    = sub_blk | (|axis_block_sigs);
    assign cnt_inc = cnt_q + CNT_ONE;
    assign cnt_sat = (cnt_q == CNT_MAX) ? cnt_q : cnt_inc;

    // Next-state, episode counter and source snapshot.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        block_d = block_q;

        if (clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            src_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cond) begin
                        cnt_d = CNT_ONE;
                        if (THRESH == 32'd1) begin
                            state_d = ST_BLOCKED;
                            src_d   = snap;
                        end else begin
                            state_d = ST_PENDING;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                ST_PENDING: begin
                    if (!cond) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_THR) begin
                            state_d = ST_BLOCKED;
                            src_d   = snap;
                        end
                    end
                end
                ST_BLOCKED: begin
                    if (cond) begin
                        cnt_d = cnt_sat;
                    end else if (STICKY == 32'd0) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        src_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    src_d   = '0;
                end
            endcase
        end

        block_d = (state_d == ST_BLOCKED);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            block_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            block_q <= block_d;
        end
    end

    assign block        = block_q;
    assign block_src    = src_q;
    assign block_cycles = cnt_q;

endmodule

// File: tb/tb_hls_deadlock_persist_monitor.sv
// Checks three monitor configurations against a run-length model of the block condition,
// using directed scenarios with literal expectations followed by random stimulus.
module tb_hls_deadlock_persist_monitor;

    logic       clock = 1'b0;
    logic       reset;
    logic       clear;
    logic [3:0] axis;
    logic [1:0] idle;
    logic [1:0] blkin;

    logic        blk0, blk1, blk2;
    logic [5:0]  src0, src1;
    logic [3:0]  src2;
    logic [15:0] cyc0;
    logic [3:0]  cyc1, cyc2;

    int total = 0;
    int bad   = 0;

    // Per-instance configuration: {THRESH, saturation value, STICKY, N_SUB}
    int p_thr[3]    = '{4, 2, 1};
    int p_max[3]    = '{65535, 15, 15};
    bit p_sticky[3] = '{1'b0, 1'b1, 1'b0};
    int p_nsub[3]   = '{2, 2, 0};

    int         m_cnt[3];
    bit         m_lat[3];
    logic [5:0] m_src[3];

    always #5 clock = ~clock;

    hls_deadlock_persist_monitor #(.N_AXIS(4), .N_SUB(2), .THRESH(4), .CNT_W(16), .STICKY(0)) u_dut0 (
        .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
        .inst_block_sigs(blkin), .clear(clear), .block(blk0), .block_src(src0), .block_cycles(cyc0));

    hls_deadlock_persist_monitor #(.N_AXIS(4), .N_SUB(2), .THRESH(2), .CNT_W(4), .STICKY(1)) u_dut1 (
        .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
        .inst_block_sigs(blkin), .clear(clear), .block(blk1), .block_src(src1), .block_cycles(cyc1));

    hls_deadlock_persist_monitor #(.N_AXIS(4), .N_SUB(0), .THRESH(1), .CNT_W(4), .STICKY(0)) u_dut2 (
        .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle[0:0]),
        .inst_block_sigs(blkin[0:0]), .clear(clear), .block(blk2), .block_src(src2), .block_cycles(cyc2));

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: length of the current blocked run, latched once it reaches THRESH.
    task automatic step_model();
        for (int i = 0; i < 3; i++) begin
            bit         cond;
            logic [5:0] snap;
            cond = (axis != 4'd0) ||
                   ((p_nsub[i] > 0) && ((idle | blkin) == 2'b11) && (blkin != 2'b00));
            snap = (p_nsub[i] > 0) ? {blkin, axis} : {2'b00, axis};
            if (reset || clear) begin
                m_cnt[i] = 0; m_lat[i] = 1'b0; m_src[i] = '0;
            end else if (cond) begin
                m_cnt[i]++;
                if (!m_lat[i] && m_cnt[i] >= p_thr[i]) begin
                    m_lat[i] = 1'b1;
                    m_src[i] = snap;
                end
            end else if (!(m_lat[i] && p_sticky[i])) begin
                m_cnt[i] = 0; m_lat[i] = 1'b0; m_src[i] = '0;
            end
        end
    endtask

    task automatic compare_all();
        int gb[3];
        int gs[3];
        int gc[3];
        gb = '{int'(blk0), int'(blk1), int'(blk2)};
        gs = '{int'(src0), int'(src1), int'(src2)};
        gc = '{int'(cyc0), int'(cyc1), int'(cyc2)};
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dut%0d.block", i), gb[i], int'(m_lat[i]));
            chk($sformatf("dut%0d.block_src", i), gs[i], int'(m_src[i]));
            chk($sformatf("dut%0d.block_cycles", i), gc[i],
                (m_cnt[i] > p_max[i]) ? p_max[i] : m_cnt[i]);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            step_model();
            #1;
            compare_all();
        end
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; axis = '0; idle = '0; blkin = '0;
        tick(2);
        chk("reset.block", int'(blk0), 0);
        chk("reset.src", int'(src0), 0);
        chk("reset.cycles", int'(cyc0), 0);
        reset = 1'b0;

        // Single stream blocked: block after THRESH cycles
        axis = 4'b0010;
        tick(3);
        chk("t1.block_early", int'(blk0), 0);
        tick(1);
        chk("t1.block", int'(blk0), 1);
        chk("t1.src", int'(src0), 6'b000010);
        chk("t1.cycles", int'(cyc0), 4);
        axis = '0;
        tick(1);
        chk("t1.drop", int'(blk0), 0);
        chk("t4.sticky_hold", int'(blk1), 1);
        chk("t4.sticky_cycles", int'(cyc1), 4);
        tick(2);
        chk("t4.sticky_frozen", int'(cyc1), 4);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("t4.clear_block", int'(blk1), 0);
        chk("t4.clear_src", int'(src1), 0);

        // A one-cycle gap restarts the count
        axis = 4'b0001; tick(3);
        axis = 4'b0000; tick(1);
        chk("t2.first_burst", int'(blk0), 0);
        axis = 4'b0001; tick(3);
        chk("t2.third", int'(blk0), 0);
        tick(1);
        chk("t2.fourth", int'(blk0), 1);

        // Sub-instance aggregation
        clear = 1'b1; axis = '0; tick(1); clear = 1'b0;
        idle = 2'b01; blkin = 2'b10;
        tick(4);
        chk("t3.sub_block", int'(blk0), 1);
        chk("t3.sub_src", int'(src0), 6'b100000);
        clear = 1'b1; tick(1); clear = 1'b0;
        idle = 2'b00; blkin = 2'b10;
        tick(6);
        chk("t3.sub_notall", int'(blk0), 0);

        // Counter saturation on the narrow instance
        idle = '0; blkin = '0;
        clear = 1'b1; tick(1); clear = 1'b0;
        axis = 4'b0100;
        tick(40);
        chk("t5.sat_cycles", int'(cyc1), 15);
        chk("t5.sat_block", int'(blk1), 1);
        chk("t5.long_cycles", int'(cyc0), 40);

        // Reset with clear while pending and while blocked; THRESH=1 latency
        clear = 1'b1; tick(1); clear = 1'b0;
        tick(2);
        reset = 1'b1; clear = 1'b1; tick(1);
        chk("t6.rst_pend_block", int'(blk0), 0);
        chk("t6.rst_pend_cycles", int'(cyc0), 0);
        reset = 1'b0; clear = 1'b0;
        tick(5);
        chk("t6.blocked", int'(blk0), 1);
        reset = 1'b1; clear = 1'b1; tick(1);
        chk("t6.rst_blk_block", int'(blk0), 0);
        chk("t6.rst_blk_src", int'(src0), 0);
        chk("t6.rst_blk_cycles", int'(cyc0), 0);
        reset = 1'b0; clear = 1'b0;
        tick(1);
        chk("t6.thresh1_block", int'(blk2), 1);
        chk("t6.thresh1_cycles", int'(cyc2), 1);

        // Random phase: sticky input patterns so runs of varied length occur
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(7) == 0)
                axis = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom);
            if ($urandom_range(7) == 0) begin
                idle  = 2'($urandom);
                blkin = 2'($urandom);
            end
            clear = ($urandom_range(63) == 0);
            reset = ($urandom_range(255) == 0);
            tick(1);
        end
        reset = 1'b0; clear = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
